dual_issue_dispatcher: RTL and testbench
========================================

Name: dual_issue_dispatcher

Overview:
- Sequences the dual-processor register-update datapath.
- Accepts one decoded instruction at a time and checks source/destination registers against a local scoreboard and the register manager's busy table.
- Boots the main or sub processor, drives its single-register renew request, and tracks each processor through launch/run/complete.
- Also implements a sync barrier that drains both processors before continuing.

Parameters:
- REGISTER_AMOUNT, 32, number of architectural registers.
- REG_CTN_WIDTH, $clog2(REGISTER_AMOUNT), register index width.
- STALL_CNT_WIDTH, 16, width of the saturating hazard-stall counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  decoded instruction offered.
- instr_ready  out  1  dispatcher accepts the offered instruction (handshake = valid & ready).
- instr_rd  in  REG_CTN_WIDTH  destination register; 0 = no write.
- instr_rs1  in  REG_CTN_WIDTH  source 1; 0 = unused.
- instr_rs2  in  REG_CTN_WIDTH  source 2; 0 = unused.
- instr_sync  in  1  barrier instruction; rd/rs fields ignored.
- processing_register_table  in  REGISTER_AMOUNT  busy bits from register manager; bit i = register i.
- processor_idle_1  in  1  main processor idle.
- processor_idle_2  in  1  sub processor idle.
- boot_renew_register_1  out  1  one-cycle renew request to main.
- boot_renew_register_2  out  1  one-cycle renew request to sub.
- register_num  out  REG_CTN_WIDTH*3  [REG_CTN_WIDTH-1:0] = issued rd; upper bits always 0.
- issue_rs1  out  REG_CTN_WIDTH  rs1 of last issued instruction; held until next issue.
- issue_rs2  out  REG_CTN_WIDTH  rs2 of last issued instruction; held until next issue.
- sync_done  out  1  one-cycle pulse when a barrier completes.
- stall_cnt  out  STALL_CNT_WIDTH  saturating count of hazard-stall cycles.

Behaviour:
- Reset values: instr_ready 1; boot_renew_register_1/2 0; register_num, issue_rs1/2 0; sync_done 0; stall_cnt 0; scoreboard all 0; hold register empty; both trackers FREE. Async reset mid-operation discards any held or in-flight instruction; no pulse is emitted afterwards.
- Hold register (1 entry): instr_ready = ~hold_valid. A handshake loads the fields and sets hold_valid. Throughput is therefore at most one instruction per 2 cycles.
- Register busy: busy(r) = (r != 0) & (scoreboard[r] | processing_register_table[r]).
- Hazard when the held instruction is non-sync and any of busy(rs1), busy(rs2), busy(rd) is true (RAW + WAW).
- Issue (cycle t): hold_valid, non-sync, no hazard, and at least one tracker FREE.
  - Main processor is chosen if tracker 1 is FREE, otherwise sub.
  - At edge t+1: the chosen boot_renew_register_n = 1 for exactly one cycle; register_num low field = rd; issue_rs1/2 latched; scoreboard[rd] set if rd != 0; tracker n -> LAUNCHED; hold_valid cleared.
- Per-processor tracker FSM (n = 1, 2):
  - FREE -> LAUNCHED on issue to n.
  - LAUNCHED -> RUN when processor_idle_n = 0.
  - RUN -> FREE when processor_idle_n = 1; scoreboard[rd_n] cleared on the same edge (rd_n latched at issue).
  - LAUNCHED holds indefinitely while idle stays 1 (no timeout).
- Sync: a held sync instruction waits until both trackers are FREE and the scoreboard is all 0. Then sync_done pulses one cycle and hold_valid clears. No processor is booted.
- Stall counting: stall_cnt increments on every cycle with hold_valid & no issue & no sync completion. It saturates at all-ones and never wraps.
- Simultaneous events:
  - Tracker clear of rd X and a held instruction reading X in the same cycle: the hazard still uses the pre-edge scoreboard, so the instruction stalls that cycle and issues the next.
  - Both trackers FREE: main always wins.
- Register 1 (return address) is treated like any other index. Register 0 is never busy and is never scoreboarded.

Test Plan:
- Independent stream: instr rd=5,rs1=2,rs2=3 then rd=6,rs1=7,rs2=0, both idle -> first boot_renew_register_1 with register_num=5, second boot_renew_register_2 with register_num=6; stall_cnt 0.
- RAW: rd=5 issued to main; main drops idle for 10 cycles; next instr rs1=5 -> stalls, issues the cycle after main idle returns; stall_cnt ≈ 11.
- External busy: processing_register_table bit 9 = 1, instr rs2=9 -> no boot while set; issues 1 cycle after the bit clears.
- Barrier: two instructions in flight, then instr_sync -> sync_done only after both idle=1 and scoreboard 0, single pulse, no boot.
- Saturation: STALL_CNT_WIDTH=4, hazard held 20 cycles -> stall_cnt = 15 and holds.
- Reset mid-operation: rst_n low while tracker 1 is RUN and hold is valid -> all outputs at reset values, instr_ready=1, no late boot or sync pulse.

Source files
------------

// File: rtl/dual_issue_dispatcher.sv
// Dual-processor dispatcher: holds one decoded instruction, checks it against a local
// scoreboard plus the register manager's busy table, and boots main/sub or drains a sync barrier.
module dual_issue_dispatcher #(
  parameter int REGISTER_AMOUNT = 32,
  parameter int REG_CTN_WIDTH   = $clog2(REGISTER_AMOUNT),
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         instr_valid,
  output logic                         instr_ready,
  input  logic [REG_CTN_WIDTH-1:0]     instr_rd,
  input  logic [REG_CTN_WIDTH-1:0]     instr_rs1,
  input  logic [REG_CTN_WIDTH-1:0]     instr_rs2,
  input  logic                         instr_sync,
  input  logic [REGISTER_AMOUNT-1:0]   processing_register_table,
  input  logic                         processor_idle_1,
  input  logic                         processor_idle_2,
  output logic                         boot_renew_register_1,
  output logic                         boot_renew_register_2,
  output logic [REG_CTN_WIDTH*3-1:0]   register_num,
  output logic [REG_CTN_WIDTH-1:0]     issue_rs1,
  output logic [REG_CTN_WIDTH-1:0]     issue_rs2,
  output logic                         sync_done,
  output logic [STALL_CNT_WIDTH-1:0]   stall_cnt
);

  typedef enum logic [1:0] {TRK_FREE, TRK_LAUNCHED, TRK_RUN} trk_state_t;
  typedef logic [REG_CTN_WIDTH-1:0] reg_idx_t;

  logic                       hold_valid;
  logic                       hold_sync;
  reg_idx_t                   hold_rd;
  reg_idx_t                   hold_rs1;
  reg_idx_t                   hold_rs2;
  logic [REGISTER_AMOUNT-1:0] scoreboard;
  logic [REGISTER_AMOUNT-1:0] scoreboard_next;
  trk_state_t                 trk_state [2];
  trk_state_t                 trk_next  [2];
  reg_idx_t                   trk_rd    [2];
  reg_idx_t                   issued_rd;

  logic [1:0] idle;
  logic [1:0] issue_to;
  logic [1:0] retire;
  logic       hazard;
  logic       any_free;
  logic       issue;
  logic       sync_fire;
  logic       stall;
  logic       handshake;

  // Register 0 is hard-wired and therefore never a dependency.
  function automatic logic busy(input reg_idx_t r,
                                input logic [REGISTER_AMOUNT-1:0] sb,
                                input logic [REGISTER_AMOUNT-1:0] tbl);
    return (r != '0) && (sb[r] || tbl[r]);
  endfunction

  assign idle        = {processor_idle_2, processor_idle_1};
  assign instr_ready = ~hold_valid;
  assign handshake   = instr_valid & ~hold_valid;

  assign hazard    = ~hold_sync & (busy(hold_rs1, scoreboard, processing_register_table) |
                                   busy(hold_rs2, scoreboard, processing_register_table) |
                                   busy(hold_rd,  scoreboard, processing_register_table));
  assign any_free  = (trk_state[0] == TRK_FREE) | (trk_state[1] == TRK_FREE);
  assign issue     = hold_valid & ~hold_sync & ~hazard & any_free;
  // Main wins whenever it is free; sub only takes work main cannot.
  assign issue_to  = {issue & (trk_state[0] != TRK_FREE), issue & (trk_state[0] == TRK_FREE)};
  assign sync_fire = hold_valid & hold_sync & (trk_state[0] == TRK_FREE) &
                     (trk_state[1] == TRK_FREE) & ~|scoreboard;
  assign stall     = hold_valid & ~issue & ~sync_fire;

  assign register_num = {{(2*REG_CTN_WIDTH){1'b0}}, issued_rd};

  // NOTE: every variable driven here gets a default before any branch, so no latch is inferred.
  always_comb begin
    retire = '0;
    for (int n = 0; n < 2; n++) begin
      trk_next[n] = trk_state[n];
      case (trk_state[n])
        TRK_FREE:     if (issue_to[n]) trk_next[n] = TRK_LAUNCHED;
        TRK_LAUNCHED: if (!idle[n])    trk_next[n] = TRK_RUN;
        TRK_RUN: if (idle[n]) begin
          trk_next[n] = TRK_FREE;
          retire[n]   = 1'b1;
        end
        default:      trk_next[n] = TRK_FREE;
      endcase
    end
  end

  // Clears come before the set; an issuing rd can never match a retiring rd
  // because that rd would still be busy and block the issue.
  always_comb begin
    scoreboard_next = scoreboard;
    for (int n = 0; n < 2; n++)
      if (retire[n]) scoreboard_next[trk_rd[n]] = 1'b0;
    if (issue && hold_rd != '0) scoreboard_next[hold_rd] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 2; n++) trk_state[n] <= TRK_FREE;
    end else begin
      for (int n = 0; n < 2; n++) trk_state[n] <= trk_next[n];
    end
  end

  // NOTE: the scoreboard is plain flops, not a RAM, so it is cleared by reset like all other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid            <= 1'b0;
      hold_sync             <= 1'b0;
      hold_rd               <= '0;
      hold_rs1              <= '0;
      hold_rs2              <= '0;
      scoreboard            <= '0;
      for (int n = 0; n < 2; n++) trk_rd[n] <= '0;
      issued_rd             <= '0;
      issue_rs1             <= '0;
      issue_rs2             <= '0;
      boot_renew_register_1 <= 1'b0;
      boot_renew_register_2 <= 1'b0;
      sync_done             <= 1'b0;
      stall_cnt             <= '0;
    end else begin
      scoreboard            <= scoreboard_next;
      boot_renew_register_1 <= issue_to[0];
      boot_renew_register_2 <= issue_to[1];
      sync_done             <= sync_fire;
      for (int n = 0; n < 2; n++)
        if (issue_to[n]) trk_rd[n] <= hold_rd;
      if (issue) begin
        issued_rd <= hold_rd;
        issue_rs1 <= hold_rs1;
        issue_rs2 <= hold_rs2;
      end
      if (handshake) begin
        hold_valid <= 1'b1;
        hold_sync  <= instr_sync;
        hold_rd    <= instr_rd;
        hold_rs1   <= instr_rs1;
        hold_rs2   <= instr_rs2;
      end else if (issue || sync_fire) begin
        hold_valid <= 1'b0;
      end
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + STALL_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_dual_issue_dispatcher.sv
// Bench for dual_issue_dispatcher: directed scenarios plus random traffic, all checked
// every cycle against a behavioural model; a second instance exercises a 4-bit stall counter.
module tb_dual_issue_dispatcher;

  localparam int RA        = 32;
  localparam int RW        = 5;
  localparam int SW        = 16;
  localparam int SW_SAT    = 4;
  localparam int STALL_MAX = (1 << SW) - 1;
  localparam int SAT_MAX   = (1 << SW_SAT) - 1;
  localparam int T_FREE = 0, T_LAUNCHED = 1, T_RUN = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_valid;
  logic [RW-1:0] instr_rd, instr_rs1, instr_rs2;
  logic          instr_sync;
  logic [RA-1:0] processing_register_table;
  logic          processor_idle_1, processor_idle_2;

  logic            instr_ready, boot1, boot2, sync_done;
  logic [3*RW-1:0] register_num;
  logic [RW-1:0]   issue_rs1, issue_rs2;
  logic [SW-1:0]   stall_cnt;

  logic              s_instr_ready, s_boot1, s_boot2, s_sync_done;
  logic [3*RW-1:0]   s_register_num;
  logic [RW-1:0]     s_issue_rs1, s_issue_rs2;
  logic [SW_SAT-1:0] stall_cnt_sat;

  int checks = 0;
  int fails  = 0;
  int cycle_no = 0;

  // behavioural model state
  bit m_hv, m_hs;
  int m_hrd, m_hrs1, m_hrs2;
  bit m_sb [RA];
  int m_trk [2];
  int m_trk_rd [2];
  bit m_boot [2];
  int m_regnum, m_rs1, m_rs2;
  bit m_sdone;
  int m_stall;

  dual_issue_dispatcher #(.REGISTER_AMOUNT(RA), .STALL_CNT_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_sync(instr_sync),
    .processing_register_table(processing_register_table),
    .processor_idle_1(processor_idle_1), .processor_idle_2(processor_idle_2),
    .boot_renew_register_1(boot1), .boot_renew_register_2(boot2),
    .register_num(register_num), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .sync_done(sync_done), .stall_cnt(stall_cnt)
  );

  dual_issue_dispatcher #(.REGISTER_AMOUNT(RA), .STALL_CNT_WIDTH(SW_SAT)) dut_sat (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(s_instr_ready),
    .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_sync(instr_sync),
    .processing_register_table(processing_register_table),
    .processor_idle_1(processor_idle_1), .processor_idle_2(processor_idle_2),
    .boot_renew_register_1(s_boot1), .boot_renew_register_2(s_boot2),
    .register_num(s_register_num), .issue_rs1(s_issue_rs1), .issue_rs2(s_issue_rs2),
    .sync_done(s_sync_done), .stall_cnt(stall_cnt_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle_no);
    $fatal(1, "watchdog");
  end

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit m_busy(input int r);
    return (r != 0) && (m_sb[r] || processing_register_table[r]);
  endfunction

  task automatic model_reset();
    m_hv = 0; m_hs = 0; m_hrd = 0; m_hrs1 = 0; m_hrs2 = 0;
    foreach (m_sb[i]) m_sb[i] = 0;
    for (int n = 0; n < 2; n++) begin
      m_trk[n] = T_FREE; m_trk_rd[n] = 0; m_boot[n] = 0;
    end
    m_regnum = 0; m_rs1 = 0; m_rs2 = 0; m_sdone = 0; m_stall = 0;
  endtask

  // One clock: advance the model from the pre-edge inputs, then compare all outputs after the edge.
  task automatic step();
    bit hazard, issue, sfire, sb_empty, pre_hv;
    bit idle [2];
    int tgt;
    idle[0] = processor_idle_1;
    idle[1] = processor_idle_2;
    hazard = !m_hs && (m_busy(m_hrd) || m_busy(m_hrs1) || m_busy(m_hrs2));
    issue  = m_hv && !m_hs && !hazard && (m_trk[0] == T_FREE || m_trk[1] == T_FREE);
    sb_empty = 1;
    foreach (m_sb[i]) if (m_sb[i]) sb_empty = 0;
    sfire = m_hv && m_hs && m_trk[0] == T_FREE && m_trk[1] == T_FREE && sb_empty;
    if (m_hv && !issue && !sfire) m_stall++;
    tgt = (m_trk[0] == T_FREE) ? 0 : 1;
    m_boot[0] = 0; m_boot[1] = 0;
    m_sdone = sfire;
    for (int n = 0; n < 2; n++) begin
      if (m_trk[n] == T_LAUNCHED && !idle[n]) m_trk[n] = T_RUN;
      else if (m_trk[n] == T_RUN && idle[n]) begin
        m_trk[n] = T_FREE;
        m_sb[m_trk_rd[n]] = 0;
      end
    end
    if (issue) begin
      m_trk[tgt] = T_LAUNCHED; m_trk_rd[tgt] = m_hrd;
      if (m_hrd != 0) m_sb[m_hrd] = 1;
      m_boot[tgt] = 1;
      m_regnum = m_hrd; m_rs1 = m_hrs1; m_rs2 = m_hrs2;
    end
    pre_hv = m_hv;
    if (issue || sfire) m_hv = 0;
    if (!pre_hv && instr_valid) begin
      m_hv = 1; m_hs = instr_sync;
      m_hrd = instr_rd; m_hrs1 = instr_rs1; m_hrs2 = instr_rs2;
    end
    @(posedge clk);
    #1;
    cycle_no++;
    checks++;
    if (instr_ready !== !m_hv) begin
      fails++; $display("FAIL model_instr_ready cycle %0d got %b want %b", cycle_no, instr_ready, !m_hv);
    end
    checks++;
    if (boot1 !== m_boot[0] || boot2 !== m_boot[1]) begin
      fails++; $display("FAIL model_boot cycle %0d got %b%b want %b%b", cycle_no, boot1, boot2, m_boot[0], m_boot[1]);
    end
    checks++;
    if (register_num !== (3*RW)'(m_regnum)) begin
      fails++; $display("FAIL model_register_num cycle %0d got %0d want %0d", cycle_no, register_num, m_regnum);
    end
    checks++;
    if (issue_rs1 !== RW'(m_rs1) || issue_rs2 !== RW'(m_rs2)) begin
      fails++; $display("FAIL model_issue_rs cycle %0d got %0d/%0d want %0d/%0d", cycle_no, issue_rs1, issue_rs2, m_rs1, m_rs2);
    end
    checks++;
    if (sync_done !== m_sdone) begin
      fails++; $display("FAIL model_sync_done cycle %0d got %b want %b", cycle_no, sync_done, m_sdone);
    end
    checks++;
    if (stall_cnt !== SW'(sat(m_stall, STALL_MAX))) begin
      fails++; $display("FAIL model_stall_cnt cycle %0d got %0d want %0d", cycle_no, stall_cnt, sat(m_stall, STALL_MAX));
    end
    checks++;
    if (stall_cnt_sat !== SW_SAT'(sat(m_stall, SAT_MAX))) begin
      fails++; $display("FAIL model_stall_sat cycle %0d got %0d want %0d", cycle_no, stall_cnt_sat, sat(m_stall, SAT_MAX));
    end
  endtask

  task automatic drive_defaults();
    instr_valid = 0; instr_sync = 0;
    instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0;
    processing_register_table = '0;
    processor_idle_1 = 1; processor_idle_2 = 1;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    drive_defaults();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  // Offer one instruction and keep stepping until the model says it was accepted.
  task automatic send(input int rd, input int rs1, input int rs2, input bit sync);
    bit done = 0;
    int n = 0;
    instr_rd = RW'(rd); instr_rs1 = RW'(rs1); instr_rs2 = RW'(rs2); instr_sync = sync;
    instr_valid = 1;
    while (!done && n < 200) begin
      done = !m_hv;
      step();
      n++;
    end
    instr_valid = 0; instr_sync = 0;
    checks++;
    if (!done) begin
      fails++; $display("FAIL send_timeout rd %0d got no handshake want handshake within 200 cycles", rd);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    drive_defaults();
    model_reset();
    #12;
    checks++;
    if (instr_ready !== 1'b1 || boot1 !== 1'b0 || boot2 !== 1'b0 || sync_done !== 1'b0) begin
      fails++; $display("FAIL reset_ctrl got rdy %b boot %b%b sync %b want 1 00 0", instr_ready, boot1, boot2, sync_done);
    end
    checks++;
    if (register_num !== '0 || issue_rs1 !== '0 || issue_rs2 !== '0 || stall_cnt !== '0 || stall_cnt_sat !== '0) begin
      fails++; $display("FAIL reset_data got regnum %0d rs %0d/%0d stall %0d/%0d want all 0",
                        register_num, issue_rs1, issue_rs2, stall_cnt, stall_cnt_sat);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic test_independent();
    apply_reset();
    send(5, 2, 3, 0);
    step();
    checks++;
    if (boot1 !== 1'b1 || boot2 !== 1'b0 || register_num !== 15'd5) begin
      fails++; $display("FAIL indep_first got boot %b%b regnum %0d want 10 5", boot1, boot2, register_num);
    end
    send(6, 7, 0, 0);
    step();
    checks++;
    if (boot1 !== 1'b0 || boot2 !== 1'b1 || register_num !== 15'd6 || issue_rs1 !== 5'd7 || issue_rs2 !== 5'd0) begin
      fails++; $display("FAIL indep_second got boot %b%b regnum %0d rs %0d/%0d want 01 6 7/0",
                        boot1, boot2, register_num, issue_rs1, issue_rs2);
    end
    checks++;
    if (stall_cnt !== 16'd0) begin
      fails++; $display("FAIL indep_stall got %0d want 0", stall_cnt);
    end
  endtask

  task automatic test_raw();
    bit early = 0;
    apply_reset();
    send(5, 0, 0, 0);
    step();
    processor_idle_1 = 0;
    send(8, 5, 0, 0);
    for (int k = 0; k < 10; k++) begin
      if (k == 9) processor_idle_1 = 1;
      step();
      if (boot1 || boot2) early = 1;
    end
    checks++;
    if (early) begin
      fails++; $display("FAIL raw_early got boot during hazard want none");
    end
    step();
    checks++;
    if (boot1 !== 1'b1 || register_num !== 15'd8 || issue_rs1 !== 5'd5 || stall_cnt !== 16'd10) begin
      fails++; $display("FAIL raw_issue got boot1 %b regnum %0d rs1 %0d stall %0d want 1 8 5 10",
                        boot1, register_num, issue_rs1, stall_cnt);
    end
  endtask

  task automatic test_external_busy();
    bit early = 0;
    apply_reset();
    processing_register_table = 32'h1 << 9;
    send(4, 0, 9, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      if (boot1 || boot2) early = 1;
    end
    checks++;
    if (early) begin
      fails++; $display("FAIL ext_busy_early got boot while bit 9 set want none");
    end
    processing_register_table = '0;
    step();
    checks++;
    if (boot1 !== 1'b1 || issue_rs2 !== 5'd9 || stall_cnt !== 16'd5) begin
      fails++; $display("FAIL ext_busy_issue got boot1 %b rs2 %0d stall %0d want 1 9 5", boot1, issue_rs2, stall_cnt);
    end
  endtask

  task automatic test_sync();
    bit early = 0;
    apply_reset();
    send(3, 0, 0, 0);
    step();
    send(4, 0, 0, 0);
    step();
    processor_idle_1 = 0;
    processor_idle_2 = 0;
    send(0, 4, 3, 1);
    for (int k = 0; k < 7; k++) begin
      if (k == 3) processor_idle_1 = 1;
      if (k == 6) processor_idle_2 = 1;
      step();
      if (sync_done || boot1 || boot2) early = 1;
    end
    checks++;
    if (early) begin
      fails++; $display("FAIL sync_early got pulse before drain want none");
    end
    step();
    checks++;
    if (sync_done !== 1'b1 || boot1 !== 1'b0 || boot2 !== 1'b0 || stall_cnt !== 16'd7) begin
      fails++; $display("FAIL sync_fire got sync %b boot %b%b stall %0d want 1 00 7", sync_done, boot1, boot2, stall_cnt);
    end
    step();
    checks++;
    if (sync_done !== 1'b0 || instr_ready !== 1'b1) begin
      fails++; $display("FAIL sync_single got sync %b rdy %b want 0 1", sync_done, instr_ready);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    processing_register_table = 32'h1 << 9;
    send(2, 9, 0, 0);
    repeat (20) step();
    checks++;
    if (stall_cnt_sat !== 4'd15 || stall_cnt !== 16'd20) begin
      fails++; $display("FAIL sat_reach got %0d/%0d want 15/20", stall_cnt_sat, stall_cnt);
    end
    repeat (3) step();
    processing_register_table = '0;
    step();
    checks++;
    if (stall_cnt_sat !== 4'd15 || stall_cnt !== 16'd23 || boot1 !== 1'b1) begin
      fails++; $display("FAIL sat_hold got %0d/%0d boot1 %b want 15/23 1", stall_cnt_sat, stall_cnt, boot1);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      instr_valid = ($urandom_range(0, 2) != 0);
      instr_sync  = ($urandom_range(0, 9) == 0);
      instr_rd    = RW'($urandom_range(0, 7));
      instr_rs1   = RW'($urandom_range(0, 7));
      instr_rs2   = RW'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0)
        processing_register_table[$urandom_range(0, 7)] = ~processing_register_table[$urandom_range(0, 7)];
      if ($urandom_range(0, 5) == 0) processing_register_table = '0;
      processor_idle_1 = ($urandom_range(0, 3) != 0);
      processor_idle_2 = ($urandom_range(0, 3) != 0);
      step();
    end
    drive_defaults();
  endtask

  task automatic test_reset_mid();
    bit late = 0;
    apply_reset();
    send(5, 0, 0, 0);
    step();
    processor_idle_1 = 0;
    step();
    send(5, 1, 0, 0);
    step();
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (instr_ready !== 1'b1 || boot1 !== 1'b0 || boot2 !== 1'b0 || sync_done !== 1'b0 ||
        register_num !== '0 || issue_rs1 !== '0 || issue_rs2 !== '0 || stall_cnt !== '0) begin
      fails++; $display("FAIL reset_mid_values got rdy %b boot %b%b sync %b regnum %0d stall %0d want 1 00 0 0 0",
                        instr_ready, boot1, boot2, sync_done, register_num, stall_cnt);
    end
    model_reset();
    processor_idle_1 = 1;
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (6) begin
      step();
      if (boot1 || boot2 || sync_done) late = 1;
    end
    checks++;
    if (late) begin
      fails++; $display("FAIL reset_mid_late got boot/sync pulse after reset want none");
    end
  endtask

  initial begin
    test_reset();
    test_independent();
    test_raw();
    test_external_busy();
    test_sync();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
